// File: rtl/hd44780_ctrl_if.sv
// rtl/hd44780_ctrl_if.sv - start/status, instruction RAM read port and LCD pin bundle for hd44780_ctrl
interface hd44780_ctrl_if #(
  parameter int ram_dwidth = 16,
  parameter int ram_awidth = 8
);
  logic                  STB_I;
  logic [ram_awidth-1:0] i_start_addr;
  logic [ram_awidth-1:0] o_read_addr_lines;
  logic [ram_dwidth-1:0] i_read_data_lines;
  logic                  busy;
  logic                  error;
  logic [3:0]            o_lcd_nybble;
  logic                  o_rs;
  logic                  o_e;

  modport master (
    input  STB_I, i_start_addr, i_read_data_lines,
    output o_read_addr_lines, busy, error, o_lcd_nybble, o_rs, o_e
  );

  modport slave (
    output STB_I, i_start_addr, i_read_data_lines,
    input  o_read_addr_lines, busy, error, o_lcd_nybble, o_rs, o_e
  );
endinterface

// File: rtl/hd44780_ctrl.sv
// rtl/hd44780_ctrl.sv - 4-bit HD44780 sequencer fetching timed control words from a sync-read RAM
module hd44780_ctrl #(
  parameter int ram_dwidth     = 16,
  parameter int ram_awidth     = 8,
  parameter int SETUP_CYC      = 2,
  parameter int E_HI_CYC       = 6,
  parameter int DELAY_UNIT_CYC = 12
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  hd44780_ctrl_if.master bus
);
  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SETUP, S_EHIGH, S_DELAY, S_NEXT
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      delay_q, delay_d;
  logic [ram_awidth-1:0] addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;
  logic                  rs_q, rs_d;
  logic                  e_q, e_d;
  logic                  end_q, end_d;
  logic [3:0]            nyb_q, nyb_d;
  logic [15:0]           word;
  logic [CNT_W-1:0]      word_n;

  assign word = bus.i_read_data_lines[15:0];

  // SCALE folds in as a left shift by 6 before the per-unit multiply
  assign word_n = (word[12] ? {18'd0, word[11:4], 6'd0} : {24'd0, word[11:4]})
                  * CNT_W'(DELAY_UNIT_CYC);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      end_q   <= 1'b0;
      nyb_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      error_q <= error_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      end_q   <= end_d;
      nyb_q   <= nyb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    error_d = error_q;
    rs_d    = rs_q;
    end_d   = end_q;
    nyb_d   = nyb_q;
    case (state_q)
      S_IDLE: begin
        if (bus.STB_I) begin
          addr_d  = bus.i_start_addr;
          busy_d  = 1'b1;
          error_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        end_d   = word[15];
        delay_d = word_n;
        if (!word[13]) begin
          rs_d    = word[14];
          nyb_d   = word[3:0];
          cnt_d   = CNT_W'(SETUP_CYC - 1);
          state_d = S_SETUP;
        end else if (word_n == '0) begin
          state_d = S_NEXT;
        end else begin
          cnt_d   = word_n - 1'b1;
          state_d = S_DELAY;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(E_HI_CYC - 1);
          state_d = S_EHIGH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EHIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (delay_q == '0) begin
          state_d = S_NEXT;
        end else begin
          cnt_d   = delay_q - 1'b1;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) state_d = S_NEXT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_NEXT: begin
        if (end_q) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (&addr_q) begin
          busy_d  = 1'b0;
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // E is registered from the next state so the pin never sees decode glitches
    e_d = (state_d == S_EHIGH);
  end

  assign bus.o_read_addr_lines = addr_q;
  assign bus.busy              = busy_q;
  assign bus.error             = error_q;
  assign bus.o_lcd_nybble      = nyb_q;
  assign bus.o_rs              = rs_q;
  assign bus.o_e               = e_q;
endmodule

// File: tb/tb_hd44780_ctrl.sv
// tb/tb_hd44780_ctrl.sv - directed bench for hd44780_ctrl with a sync-read RAM model
module tb_hd44780_ctrl;
  logic clk;
  logic rst;
  logic [15:0] mem [256];

  int checks = 0;
  int passes = 0;

  int busy_cyc, e_cyc, e_pulses, first_e, n_addr;
  logic prev_e;
  logic [3:0] nyb_log [4];
  logic       rs_log  [4];
  logic [7:0] addr_log [8];

  hd44780_ctrl_if #(.ram_dwidth(16), .ram_awidth(8)) bus ();

  hd44780_ctrl #(
    .ram_dwidth(16), .ram_awidth(8), .SETUP_CYC(2), .E_HI_CYC(6), .DELAY_UNIT_CYC(12)
  ) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.i_read_data_lines <= mem[bus.o_read_addr_lines];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Strobe once, then sample every negedge while busy; optional second strobe at cycle 'again'
  task automatic run(input logic [7:0] a, input int limit, input int again);
    busy_cyc = 0; e_cyc = 0; e_pulses = 0; first_e = -1; n_addr = 0; prev_e = 1'b0;
    @(negedge clk);
    bus.STB_I = 1'b1;
    bus.i_start_addr = a;
    @(negedge clk);
    bus.STB_I = 1'b0;
    while (bus.busy && busy_cyc < limit) begin
      busy_cyc++;
      if (bus.o_e) begin
        e_cyc++;
        if (!prev_e) begin
          if (first_e < 0) first_e = busy_cyc - 1;
          if (e_pulses < 4) begin
            nyb_log[e_pulses] = bus.o_lcd_nybble;
            rs_log[e_pulses]  = bus.o_rs;
          end
          e_pulses++;
        end
      end
      prev_e = bus.o_e;
      if ((n_addr == 0 || addr_log[n_addr-1] != bus.o_read_addr_lines) && n_addr < 8) begin
        addr_log[n_addr] = bus.o_read_addr_lines;
        n_addr++;
      end
      bus.STB_I        = (busy_cyc == again);
      bus.i_start_addr = (busy_cyc == again) ? 8'h40 : a;
      @(negedge clk);
    end
    bus.STB_I = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst = 1'b1;
    bus.STB_I = 1'b0;
    bus.i_start_addr = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_e", bus.o_e, 0);
    chk("rst_rs", bus.o_rs, 0);
    chk("rst_nyb", bus.o_lcd_nybble, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_addr", bus.o_read_addr_lines, 0);
    rst = 1'b0;

    mem[0] = 16'hC015;
    run(8'h00, 2000, -1);
    chk("a_busy_cyc", busy_cyc, 23);
    chk("a_e_cyc", e_cyc, 6);
    chk("a_e_pulses", e_pulses, 1);
    chk("a_first_e", first_e, 4);
    chk("a_nyb", nyb_log[0], 4'h5);
    chk("a_rs", rs_log[0], 1);
    chk("a_error", bus.error, 0);
    chk("a_busy_end", bus.busy, 0);
    chk("a_nyb_hold", bus.o_lcd_nybble, 4'h5);

    mem[8'h10] = 16'h0003;
    mem[8'h11] = 16'h8002;
    mem[8'h40] = 16'hC00F;
    run(8'h10, 2000, 5);
    chk("b_busy_cyc", busy_cyc, 22);
    chk("b_e_pulses", e_pulses, 2);
    chk("b_e_cyc", e_cyc, 12);
    chk("b_nyb0", nyb_log[0], 4'h3);
    chk("b_nyb1", nyb_log[1], 4'h2);
    chk("b_rs0", rs_log[0], 0);
    chk("b_rs1", rs_log[1], 0);
    chk("b_n_addr", n_addr, 2);
    chk("b_addr0", addr_log[0], 8'h10);
    chk("b_addr1", addr_log[1], 8'h11);
    chk("b_busy_end", bus.busy, 0);

    mem[0] = 16'hA0A0;
    run(8'h00, 2000, -1);
    chk("c_busy_cyc", busy_cyc, 123);
    chk("c_e_pulses", e_pulses, 0);
    chk("c_nyb_hold", bus.o_lcd_nybble, 4'h2);
    chk("c_rs_hold", bus.o_rs, 0);

    mem[0] = 16'hB010;
    run(8'h00, 2000, -1);
    chk("c2_busy_cyc", busy_cyc, 771);
    chk("c2_e_pulses", e_pulses, 0);

    mem[8'hFF] = 16'h0001;
    run(8'hFF, 2000, -1);
    chk("d_busy_cyc", busy_cyc, 11);
    chk("d_e_pulses", e_pulses, 1);
    chk("d_nyb", nyb_log[0], 4'h1);
    chk("d_error", bus.error, 1);
    chk("d_busy_end", bus.busy, 0);
    chk("d_n_addr", n_addr, 1);

    mem[0] = 16'hC015;
    run(8'h00, 2000, -1);
    chk("d2_error_clr", bus.error, 0);
    chk("d2_busy_cyc", busy_cyc, 23);

    // Assert reset between edges while E is high
    @(negedge clk);
    bus.STB_I = 1'b1;
    bus.i_start_addr = 8'h00;
    @(negedge clk);
    bus.STB_I = 1'b0;
    for (int i = 0; i < 50 && !bus.o_e; i++) @(negedge clk);
    chk("e_seen", bus.o_e, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_e", bus.o_e, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rs", bus.o_rs, 0);
    chk("mid_rst_nyb", bus.o_lcd_nybble, 0);
    chk("mid_rst_error", bus.error, 0);
    chk("mid_rst_addr", bus.o_read_addr_lines, 0);
    @(negedge clk);
    rst = 1'b0;
    run(8'h00, 2000, -1);
    chk("post_rst_busy_cyc", busy_cyc, 23);
    chk("post_rst_e_pulses", e_pulses, 1);
    chk("post_rst_first_e", first_e, 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
